// File: rtl/uart_tx_framer_if.sv
// Word handshake between the TX FIFO (master) and the UART transmit framer (slave).
interface uart_tx_framer_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: takes one word over valid/ready, builds
// start + data (LSB first) + optional parity + stop bits, and shifts it out on
// tx at one bit per baud_tick.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | line idle high, ready for a word, baud_tick ignored
// S_WAIT | word latched, waiting for the next tick to load the frame
// S_SEND | frame on the line, one bit per tick, done on the last one
module uart_tx_framer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             baud_tick,
   uart_tx_framer_if.slave  tx_if,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int FRAME = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
   localparam int CW    = $clog2(FRAME + 1);

   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_framer: DATA_BITS must be 5..9");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_tx_framer: STOP_BITS must be 1..2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [FRAME-1:0]     shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_q, par_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic [FRAME-1:0]     frame_w;

   // Next-state, frame assembly and registered-output decode.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      par_d   = par_q;
      done_d  = 1'b0;

      // Stop bits and any unused top bits stay 1; bit 0 is the start bit.
      frame_w               = '1;
      frame_w[0]            = 1'b0;
      frame_w[DATA_BITS:1]  = data_q;
      if (PARITY_EN != 0) begin
         frame_w[DATA_BITS+1] = par_q;
      end

      case (state_q)
         S_IDLE: begin
            if (tx_if.tx_valid) begin
               data_d  = tx_if.tx_data;
               par_d   = (PARITY_ODD != 0) ? ~^tx_if.tx_data : ^tx_if.tx_data;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (baud_tick) begin
               shift_d = frame_w;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (baud_tick) begin
               shift_d = {1'b1, shift_q[FRAME-1:1]};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(FRAME - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            shift_d = '1;
            cnt_d   = '0;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   // All framer state; reset drops any frame in flight and returns the line high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '1;
         cnt_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         par_q   <= par_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign tx             = shift_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign tx_if.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: six parameter sets side by side, a frame-level
// reference model and a per-cycle compare against every instance.
module tb_uart_tx_framer;

   localparam int NI = 6;

   // 0: 8N1  1: 8E1  2: 8O1  3: 8N2  4: 5N1  5: 9N1
   function automatic int cfg_db(int g);
      return (g == 4) ? 5 : ((g == 5) ? 9 : 8);
   endfunction
   function automatic int cfg_pe(int g);
      return ((g == 1) || (g == 2)) ? 1 : 0;
   endfunction
   function automatic int cfg_po(int g);
      return (g == 2) ? 1 : 0;
   endfunction
   function automatic int cfg_sb(int g);
      return (g == 3) ? 2 : 1;
   endfunction
   function automatic int flen(int g);
      return 1 + cfg_db(g) + cfg_pe(g) + cfg_sb(g);
   endfunction

   // Frame bits as they must appear on the line, bit 0 first.
   function automatic logic [11:0] build(int g, logic [8:0] d);
      logic [11:0] f;
      logic        p;
      int          n;
      n = cfg_db(g);
      p = 1'b0;
      for (int k = 0; k < n; k++) p = p ^ d[k];
      if (cfg_po(g) != 0) p = ~p;
      f = '1;
      for (int i = 0; i < flen(g); i++) begin
         if (i == 0)                            f[i] = 1'b0;
         else if (i <= n)                       f[i] = d[i-1];
         else if ((cfg_pe(g) != 0) && (i == n + 1)) f[i] = p;
         else                                   f[i] = 1'b1;
      end
      return f;
   endfunction

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick = 1'b0;
   logic          tick_en = 1'b0;
   int            tcnt = 0;
   logic          valid_a [NI];
   logic [8:0]    data_a  [NI];
   logic [NI-1:0] ready_v, tx_v, busy_v, done_v;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DB = cfg_db(g);
      uart_tx_framer_if #(.DATA_BITS(DB)) ifc ();
      assign ifc.tx_valid = valid_a[g];
      assign ifc.tx_data  = data_a[g][DB-1:0];
      assign ready_v[g]   = ifc.tx_ready;
      uart_tx_framer #(
         .DATA_BITS (DB),
         .PARITY_EN (cfg_pe(g)),
         .PARITY_ODD(cfg_po(g)),
         .STOP_BITS (cfg_sb(g))
      ) dut (
         .clk      (clk),
         .reset    (rst),
         .baud_tick(tick),
         .tx_if    (ifc),
         .tx       (tx_v[g]),
         .busy     (busy_v[g]),
         .done     (done_v[g])
      );
   end

   // Baud tick: one clk high every 16 clk, changed on the falling edge.
   always @(negedge clk) begin
      if (tick_en) begin
         tcnt <= (tcnt == 15) ? 0 : tcnt + 1;
         tick <= (tcnt == 15);
      end else begin
         tick <= 1'b0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 word held, 2 frame on line at bit m_idx.
   int          m_phase [NI];
   int          m_idx   [NI];
   logic [11:0] m_frame [NI];
   logic        m_done  [NI];
   int          tick_total = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NI; g++) begin
            m_phase[g] <= 0;
            m_idx[g]   <= 0;
            m_frame[g] <= '1;
            m_done[g]  <= 1'b0;
         end
      end else begin
         if (tick) tick_total <= tick_total + 1;
         for (int g = 0; g < NI; g++) begin
            m_done[g] <= 1'b0;
            if (m_phase[g] == 0) begin
               if (valid_a[g]) begin
                  m_frame[g] <= build(g, data_a[g]);
                  m_phase[g] <= 1;
               end
            end else if (m_phase[g] == 1) begin
               if (tick) begin
                  m_idx[g]   <= 0;
                  m_phase[g] <= 2;
               end
            end else if (tick) begin
               if (m_idx[g] == flen(g) - 1) begin
                  m_phase[g] <= 0;
                  m_done[g]  <= 1'b1;
               end else begin
                  m_idx[g] <= m_idx[g] + 1;
               end
            end
         end
      end
   end

   // Cycle-by-cycle compare of every instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NI; g++) begin
            chk($sformatf("u%0d tx", g), int'(tx_v[g]),
                (m_phase[g] == 2) ? int'(m_frame[g][m_idx[g]]) : 1);
            chk($sformatf("u%0d tx_ready", g), int'(ready_v[g]), (m_phase[g] == 0) ? 1 : 0);
            chk($sformatf("u%0d busy", g), int'(busy_v[g]), (m_phase[g] != 0) ? 1 : 0);
            chk($sformatf("u%0d done", g), int'(done_v[g]), int'(m_done[g]));
         end
      end
   end

   task automatic send(input int g, input logic [8:0] d, output int t0);
      @(negedge clk); #1;
      valid_a[g] = 1'b1;
      data_a[g]  = d;
      @(posedge clk);
      @(negedge clk);
      t0 = tick_total;
      #1;
      valid_a[g] = 1'b0;
      data_a[g]  = 9'h0AA;
   endtask

   task automatic wait_done(input int g, input int t0, input int exp_ticks);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk); #2;
         if (done_v[g]) seen = 1'b1;
      end
      chk($sformatf("u%0d done within budget", g), int'(seen), 1);
      if (exp_ticks > 0) chk($sformatf("u%0d ticks accept->done", g), tick_total - t0, exp_ticks);
   endtask

   initial begin
      int   t0, run, nruns, bad, gap;
      logic started, last, got_done, found;
      for (int g = 0; g < NI; g++) begin
         valid_a[g] = 1'b0;
         data_a[g]  = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("reset tx", int'(tx_v), 63);
      chk("reset tx_ready", int'(ready_v), 63);
      chk("reset busy", int'(busy_v), 0);
      chk("reset done", int'(done_v), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick_en = 1'b1;

      chk("model 8N1 0x55", int'(build(0, 9'h055)), 12'h2AA | 12'hC00);
      chk("model 8E1 0x07", int'(build(1, 9'h007)), 12'h60E | 12'h800);
      chk("model 8O1 0x07", int'(build(2, 9'h007)), 12'h40E | 12'h800);
      chk("model 8N2 0xFF", int'(build(3, 9'h0FF)), 12'h7FE | 12'h800);
      chk("model 5N1 0x1F", int'(build(4, 9'h01F)), 12'hFFE);
      chk("model 9N1 0x1A5", int'(build(5, 9'h1A5)), 12'h74A | 12'h800);

      // 8N1 0x55: ten alternating bits, each exactly 16 clk.
      send(0, 9'h055, t0);
      started = 1'b0; last = 1'b1; run = 0; nruns = 0; bad = 0; got_done = 1'b0;
      for (int c = 0; c < 400 && !got_done; c++) begin
         @(negedge clk); #2;
         if (done_v[0]) got_done = 1'b1;
         else if (started || (tx_v[0] == 1'b0)) begin
            if (!started) begin
               started = 1'b1; last = 1'b0; run = 1;
            end else if (tx_v[0] == last) run++;
            else begin
               nruns++;
               if (run != 16) bad++;
               last = tx_v[0];
               run = 1;
            end
         end
      end
      nruns++;
      if (run != 16) bad++;
      chk("8N1 done seen", int'(got_done), 1);
      chk("8N1 bit runs", nruns, 10);
      chk("8N1 runs not 16 clk", bad, 0);
      chk("8N1 ticks accept->done", tick_total - t0, 11);

      send(1, 9'h007, t0);  wait_done(1, t0, 12);
      send(2, 9'h007, t0);  wait_done(2, t0, 12);
      send(3, 9'h0FF, t0);  wait_done(3, t0, 12);
      send(4, 9'h01F, t0);  wait_done(4, t0, 8);
      send(5, 9'h1A5, t0);  wait_done(5, t0, 12);

      // Accept on the same edge as a tick: load waits for the following tick.
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk); #1;
         if (tick) found = 1'b1;
      end
      chk("tick alignment found", int'(found), 1);
      valid_a[0] = 1'b1;
      data_a[0]  = 9'h0A3;
      @(posedge clk);
      @(negedge clk);
      t0 = tick_total;
      #1;
      valid_a[0] = 1'b0;
      chk("same-edge accept tx still high", int'(tx_v[0]), 1);
      chk("same-edge accept busy", int'(busy_v[0]), 1);
      wait_done(0, t0, 11);

      // Valid held through the frame: second word goes after done plus an idle bit.
      @(negedge clk); #1;
      valid_a[0] = 1'b1;
      data_a[0]  = 9'h03C;
      @(posedge clk);
      @(negedge clk); #1;
      data_a[0] = 9'h0C3;
      wait_done(0, 0, 0);
      gap = 1;
      @(negedge clk); #1;
      valid_a[0] = 1'b0;
      for (int c = 0; c < 100 && tx_v[0] == 1'b1; c++) begin
         gap++;
         @(negedge clk); #1;
      end
      chk("b2b idle gap >= 16 clk", int'(gap >= 16), 1);
      wait_done(0, 0, 0);

      // Reset mid-frame after the 4th frame tick.
      send(0, 9'h096, t0);
      for (int c = 0; c < 200 && (tick_total - t0) < 5; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      chk("pre-reset busy", int'(busy_v[0]), 1);
      rst = 1'b1;
      #1;
      chk("mid reset tx", int'(tx_v[0]), 1);
      chk("mid reset busy", int'(busy_v[0]), 0);
      chk("mid reset tx_ready", int'(ready_v[0]), 1);
      chk("mid reset done", int'(done_v[0]), 0);
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      send(0, 9'h05A, t0);
      wait_done(0, t0, 11);

      repeat (20) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
